// File: rtl/load_tag_buf_pkg.sv
// Shared types for the load tag buffer: per-entry lifecycle state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package load_tag_buf_pkg;

  // FREE: unused; PEND: waiting for its dcache response;
  // KILLED: flushed while in flight, response will be swallowed.
  typedef enum logic [1:0] {
    LTB_FREE   = 2'd0,
    LTB_PEND   = 2'd1,
    LTB_KILLED = 2'd2
  } ltb_state_e;

endpackage

// File: rtl/ltb_age_fifo.sv
// Age-ordered FIFO of issued tags; head is the oldest load still tracked.
// Latency: push visible at head one cycle later; head_dat is a registered read.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module ltb_age_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             push_vld,
  input  logic [Width-1:0] push_dat,
  input  logic             pop_vld,
  output logic             head_vld,
  output logic [Width-1:0] head_dat
);

  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned Slots = 2 ** PtrW;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Slots];
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [CntW-1:0]  cnt_q;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  assign head_vld = (cnt_q != '0);
  assign head_dat = mem_q[rd_ptr_q];

  // Ring buffer storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(Slots); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_vld) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_vld) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(push_vld) - CntW'(pop_vld);
    end
  end

endmodule

// File: rtl/load_tag_buffer.sv
// Tracks outstanding dcache loads: grants tags, stores metadata, matches responses, kills on flush.
// Latency: tag grant and response forwarding are combinational; entry state updates on the next edge.
// Backpressure: alloc_ready_o low when full or flushing; InOrder=1 holds non-head responses via rsp_ready_o.
module load_tag_buffer
  import load_tag_buf_pkg::*;
#(
  parameter int unsigned  NrEntries = 2,
  parameter int unsigned  MetaWidth = 16,
  parameter int unsigned  InOrder   = 0,
  localparam int unsigned TagWidth  = (NrEntries > 1) ? $clog2(NrEntries) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 alloc_valid_i,
  input  logic [MetaWidth-1:0] alloc_meta_i,
  output logic                 alloc_ready_o,
  output logic [TagWidth-1:0]  alloc_tag_o,
  input  logic                 rsp_valid_i,
  input  logic [TagWidth-1:0]  rsp_tag_i,
  output logic                 rsp_ready_o,
  output logic                 out_valid_o,
  output logic [MetaWidth-1:0] out_meta_o,
  output logic [TagWidth:0]    count_o,
  output logic                 idle_o,
  output logic                 err_o
);

  // Arrays cover every encodable tag; slots at or above NrEntries stay FREE
  // forever, so an out-of-range tag naturally reads as a FREE-entry error.
  localparam int unsigned Depth = 2 ** TagWidth;
  localparam int unsigned CntW  = TagWidth + 1;

  ltb_state_e           state_q [Depth];
  logic [MetaWidth-1:0] meta_q  [Depth];
  logic [CntW-1:0]      count_q;
  logic                 err_q;

  logic                 free_found;
  logic [TagWidth-1:0]  free_idx;
  ltb_state_e           rsp_state;
  logic                 rsp_bad;
  logic                 alloc_fire;
  logic                 rsp_free;

  // Lowest-index FREE entry, taken from registered state only.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(NrEntries) - 1; i >= 0; i--) begin
      if (state_q[i] == LTB_FREE) begin
        free_found = 1'b1;
        free_idx   = TagWidth'(i);
      end
    end
  end

  assign rsp_state     = state_q[rsp_tag_i];
  assign rsp_bad       = (rsp_state == LTB_FREE);
  assign alloc_ready_o = free_found & ~flush_i;
  assign alloc_tag_o   = free_idx;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;
  // A bad beat is accepted so it cannot wedge the cache port, but frees nothing.
  assign rsp_free      = rsp_valid_i & rsp_ready_o & ~rsp_bad;
  assign out_valid_o   = rsp_free & (rsp_state == LTB_PEND) & ~flush_i;
  assign out_meta_o    = meta_q[rsp_tag_i];
  assign count_o       = count_q;
  assign idle_o        = (count_q == '0);
  assign err_o         = err_q;

  generate
    if (InOrder != 0) begin : g_in_order
      logic                head_vld;
      logic [TagWidth-1:0] head_dat;

      ltb_age_fifo #(
        .Depth (NrEntries),
        .Width (TagWidth)
      ) u_age_fifo (
        .core_clk (clk_i),
        .arst_n   (rst_ni),
        .push_vld (alloc_fire),
        .push_dat (free_idx),
        .pop_vld  (rsp_free),
        .head_vld (head_vld),
        .head_dat (head_dat)
      );

      // Only the oldest tracked tag (live or killed) may complete.
      assign rsp_ready_o = ~rsp_valid_i | rsp_bad | (head_vld & (rsp_tag_i == head_dat));
    end else begin : g_any_order
      assign rsp_ready_o = 1'b1;
    end
  endgenerate

  // Entry lifecycle: alloc -> PEND, response -> FREE, flush kills the remaining PEND.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        state_q[i] <= LTB_FREE;
        meta_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NrEntries); i++) begin
        if (alloc_fire && free_idx == TagWidth'(i)) begin
          state_q[i] <= LTB_PEND;
          meta_q[i]  <= alloc_meta_i;
        end else if (rsp_free && rsp_tag_i == TagWidth'(i)) begin
          state_q[i] <= LTB_FREE;
        end else if (flush_i && state_q[i] == LTB_PEND) begin
          state_q[i] <= LTB_KILLED;
        end
      end
    end
  end

  // Occupancy counter and sticky error for responses that hit no tracked entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_q + CntW'(alloc_fire) - CntW'(rsp_free);
      if (rsp_valid_i && rsp_bad) err_q <= 1'b1;
    end
  end

endmodule
